iq_window_seq: RTL and testbench
================================

# iq_window_seq

Upstream stage of the I/Q demodulator pair selector. Collects a stream of 9-bit signed samples into 10-sample windows, holds each completed window stable on ten parallel outputs, and steps a 3-bit pair select 0→4 with a valid/ready handshake so the downstream selector emits one sample pair per accepted beat. A capture buffer plus a hold bank give one window of slack. Later windows that arrive while that slack is used are dropped and accounted for.

## Interface
- `WIDTH`, 9, sample width (signed two's complement)
- `DEPTH`, 10, samples per window; fixed even; pairs = DEPTH/2 = 5
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `sample_in` input WIDTH: incoming sample
- `sample_valid` input 1: sample_in valid this cycle
- `pair_ready` input 1: downstream accepts current pair
- `win_0` … `win_9` output WIDTH each: hold-bank samples, win_k = k-th sample of window
- `sel` output 3: pair index 0..4
- `pair_valid` output 1: sel/win_* valid
- `pair_last` output 1: pair_valid && sel==4
- `busy` output 1: state SEQ or capture pending
- `ovf` output 1: sticky overflow (IQ_WIN_OVF_STATUS_EN only)
- `drop_cnt` output 8: saturating dropped-sample count (IQ_WIN_OVF_STATUS_EN only)

## Operation
- Capture buffer: `fill` counter 0..9; on an accepted sample, cap[fill] <= sample_in, fill++; at fill==9, fill <= 0 and `pending` <= 1.
- Bank free condition (`xfer_ok`): state IDLE, or state SEQ && sel==4 && pair_ready.
- Transfer: pending && xfer_ok → bank <= cap, pending <= 0, state SEQ, sel <= 0.
- States: IDLE (pair_valid=0, sel=0). SEQ (pair_valid=1). On SEQ && pair_ready && sel<4, sel++. On SEQ && pair_ready && sel==4, go to IDLE unless a transfer occurs in that cycle; a transfer keeps SEQ with sel=0 back-to-back.
- Sample acceptance: accepted if sample_valid && (!pending || transfer this cycle). Capture writes and the transfer may occur in the same cycle. The bank copies the old cap contents, and the new sample lands in cap[0].
- Drop: sample_valid && pending && no transfer → sample discarded. fill is unchanged. This is counted as an overflow event.
- Bank and sel stay constant while pair_valid && !pair_ready.
- pair_ready ignored in IDLE.
- Samples pass through unmodified; no arithmetic on data.

## Timing
- Reset: fill=0, pending=0, state IDLE, sel=0, pair_valid=0, pair_last=0, busy=0, win_*=0, ovf=0, drop_cnt=0. Any cycle; mid-window or mid-sequence contents discarded.
- Latency: 10th sample valid in cycle N with bank free → pair_valid, sel=0 in cycle N+2.
- Full sequence with pair_ready=1: 5 cycles (sel 0,1,2,3,4), pair_last in the 5th.
- Simultaneous final accept + pending: no bubble; the next cycle shows sel=0 of the new window.
- Continuous input (one sample per cycle) with pair_ready=1 never overflows (5-cycle drain < 10-cycle fill).

## Configuration
- `IQ_WIN_OVF_STATUS_EN` defined: ovf set on the first drop, cleared only by rst. drop_cnt increments per dropped sample and saturates at 255.
- Undefined: drops remain silent; ovf and drop_cnt tied 0; no counter logic.

## Structure
- Package `iq_demod_pkg`: WIDTH, DEPTH, NPAIR constants; `sample_t` (logic signed [WIDTH-1:0]); `win_state_t` enum {IDLE, SEQ}.
- Sub-module `iq_win_capture`: capture buffer, fill counter, pending flag, drop detect; top holds bank, FSM, handshake, status.

## Test plan
- Reset: assert rst 2 cycles mid-stream → all outputs 0 the next cycle; the following window is built from fresh samples only.
- Basic: samples 1..10 continuous, pair_ready=1 → sel 0..4 in cycles N+2..N+6, win_k=k+1, pair_last at sel=4 only.
- Backpressure: pair_ready=0 for 3 cycles at sel=2 → sel=2, win_* stable for 3 cycles, then 3,4.
- Back-to-back: hold pair_ready=0 until a second window is pending, then pair_ready=1 → sel goes 4→0 with no pair_valid gap and the second window appears.
- Overflow: pair_ready=0, 30 continuous samples → window 1 in bank, window 2 pending, 10 dropped: drop_cnt=10, ovf=1 (macro on); both =0 (macro off).
- Gapped input: sample_valid every 3rd cycle, values 100..109 → win_k=100+k, five pairs delivered.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared constants and types for the I/Q window sequencer slice.
// Optional status counters are enabled with the IQ_WIN_OVF_STATUS_EN macro.
package iq_demod_pkg;
    localparam int WIDTH = 9;
    localparam int DEPTH = 10;
    localparam int NPAIR = DEPTH / 2;

    // Last fill index and last pair index, sized to their counters.
    localparam logic [3:0] FILL_LAST = 4'(DEPTH - 1);
    localparam logic [2:0] SEL_LAST  = 3'(NPAIR - 1);

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } win_state_t;
endpackage

// File: rtl/iq_window_seq_if.sv
// Sample stream in, held window plus pair-select handshake out.
// Handshake: a pair beat (sel, win_*) is offered while pair_valid is high and
// is consumed on a rising clock edge where pair_valid && pair_ready; the beat
// stays unchanged until consumed. sample_valid has no back-pressure: a sample
// that cannot be stored is dropped and reported through ovf/drop_cnt.
interface iq_window_seq_if;
    import iq_demod_pkg::*;

    sample_t    sample_in;
    logic       sample_valid;
    logic       pair_ready;
    sample_t    win_0, win_1, win_2, win_3, win_4;
    sample_t    win_5, win_6, win_7, win_8, win_9;
    logic [2:0] sel;
    logic       pair_valid;
    logic       pair_last;
    logic       busy;
    logic       ovf;
    logic [7:0] drop_cnt;

    modport master (
        output sample_in, sample_valid, pair_ready,
        input  win_0, win_1, win_2, win_3, win_4,
        input  win_5, win_6, win_7, win_8, win_9,
        input  sel, pair_valid, pair_last, busy, ovf, drop_cnt
    );

    modport slave (
        input  sample_in, sample_valid, pair_ready,
        output win_0, win_1, win_2, win_3, win_4,
        output win_5, win_6, win_7, win_8, win_9,
        output sel, pair_valid, pair_last, busy, ovf, drop_cnt
    );
endinterface

// File: rtl/iq_win_capture.sv
// Capture buffer: gathers DEPTH samples, flags a complete window as pending
// until the top copies it into the hold bank, and detects dropped samples.
// The drop output exists only when IQ_WIN_OVF_STATUS_EN is defined.
module iq_win_capture
    import iq_demod_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  sample_t sample_in,
    input  logic    sample_valid,
    input  logic    xfer,
    output sample_t cap [DEPTH],
    output logic    pending
`ifdef IQ_WIN_OVF_STATUS_EN
    ,
    output logic    drop
`endif
);
    logic [3:0] fill;
    logic       accept;

    // A full buffer still accepts when the bank takes it in the same cycle.
    assign accept = sample_valid && (!pending || xfer);

`ifdef IQ_WIN_OVF_STATUS_EN
    assign drop = sample_valid && pending && !xfer;
`endif

    // Store accepted samples, wrap the fill index, track the pending window.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill    <= '0;
            pending <= 1'b0;
            for (int k = 0; k < DEPTH; k++) cap[k] <= '0;
        end else begin
            if (accept) begin
                cap[fill] <= sample_in;
                fill      <= (fill == FILL_LAST) ? 4'd0 : fill + 4'd1;
            end
            // A window completing in the transfer cycle re-arms pending.
            if (accept && fill == FILL_LAST) pending <= 1'b1;
            else if (xfer)                   pending <= 1'b0;
        end
    end
endmodule

// File: rtl/iq_window_seq.sv
// Window sequencer top: hold bank, IDLE/SEQ pair stepper, status outputs.
// Define IQ_WIN_OVF_STATUS_EN to build the sticky ovf flag and drop counter.
module iq_window_seq
    import iq_demod_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    iq_window_seq_if.slave  bus,
    output win_state_t      state_dbg
);
    sample_t    cap  [DEPTH];
    sample_t    bank [DEPTH];
    logic       pending;
    logic       xfer_ok;
    logic       xfer;
    win_state_t state;
    logic [2:0] sel;
    logic       pair_valid;
    logic       pair_last;
`ifdef IQ_WIN_OVF_STATUS_EN
    logic       drop;
`endif

    // Bank is free when idle or when its last pair is consumed this cycle.
    assign xfer_ok = (state == IDLE) ||
                     (state == SEQ && sel == SEL_LAST && bus.pair_ready);
    assign xfer    = pending && xfer_ok;

    iq_win_capture u_capture (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (bus.sample_in),
        .sample_valid (bus.sample_valid),
        .xfer         (xfer),
        .cap          (cap),
        .pending      (pending)
`ifdef IQ_WIN_OVF_STATUS_EN
        ,
        .drop         (drop)
`endif
    );

    // Pair stepper FSM with registered handshake outputs and bank load.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            pair_valid <= 1'b0;
            pair_last  <= 1'b0;
            for (int k = 0; k < DEPTH; k++) bank[k] <= '0;
        end else if (xfer) begin
            for (int k = 0; k < DEPTH; k++) bank[k] <= cap[k];
            state      <= SEQ;
            sel        <= '0;
            pair_valid <= 1'b1;
            pair_last  <= 1'b0;
        end else if (state == SEQ && bus.pair_ready) begin
            if (sel == SEL_LAST) begin
                state      <= IDLE;
                sel        <= '0;
                pair_valid <= 1'b0;
                pair_last  <= 1'b0;
            end else begin
                sel        <= sel + 3'd1;
                pair_last  <= (sel == SEL_LAST - 3'd1);
            end
        end
    end

    assign bus.win_0      = bank[0];
    assign bus.win_1      = bank[1];
    assign bus.win_2      = bank[2];
    assign bus.win_3      = bank[3];
    assign bus.win_4      = bank[4];
    assign bus.win_5      = bank[5];
    assign bus.win_6      = bank[6];
    assign bus.win_7      = bank[7];
    assign bus.win_8      = bank[8];
    assign bus.win_9      = bank[9];
    assign bus.sel        = sel;
    assign bus.pair_valid = pair_valid;
    assign bus.pair_last  = pair_last;
    assign bus.busy       = (state == SEQ) || pending;
    assign state_dbg      = state;

`ifdef IQ_WIN_OVF_STATUS_EN
    logic       ovf_q;
    logic [7:0] drop_cnt_q;

    // Sticky overflow flag and saturating dropped-sample count.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign bus.ovf      = ovf_q;
    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.ovf      = 1'b0;
    assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_iq_window_seq.sv
// Directed bench for iq_window_seq: a cycle table for the basic window,
// then hand sequences for reset, backpressure, back-to-back, overflow,
// gapped input and drop-counter saturation.
module tb_iq_window_seq;
    import iq_demod_pkg::*;

`ifdef IQ_WIN_OVF_STATUS_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    win_state_t state_dbg;

    iq_window_seq_if bus();

    iq_window_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic [WIDTH-1:0] win_obs [DEPTH];
    assign win_obs[0] = bus.win_0;
    assign win_obs[1] = bus.win_1;
    assign win_obs[2] = bus.win_2;
    assign win_obs[3] = bus.win_3;
    assign win_obs[4] = bus.win_4;
    assign win_obs[5] = bus.win_5;
    assign win_obs[6] = bus.win_6;
    assign win_obs[7] = bus.win_7;
    assign win_obs[8] = bus.win_8;
    assign win_obs[9] = bus.win_9;

    // Scoreboard: every accepted sample expected in the next window shown.
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] cur_win [DEPTH];
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic             sv;
        logic [WIDTH-1:0] din;
        logic             pr;
        logic             pv;
        logic [2:0]       sel;
        logic             last;
        logic             busy;
    } vec_t;
    vec_t vt [17];

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_window(input int base, input int gap);
        logic [WIDTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = 9'(base + i);
            exp_q.push_back(v);
            bus.sample_valid = 1'b1;
            bus.sample_in    = v;
            tick();
            bus.sample_valid = 1'b0;
            if (i < DEPTH - 1) repeat (gap - 1) tick();
        end
    endtask

    task automatic wait_pv(input string tag, input int max_cycles);
        int n = 0;
        while (!bus.pair_valid && n < max_cycles) begin
            tick();
            n++;
        end
        chk({tag, " pair_valid within budget"}, 32'(bus.pair_valid), 32'd1);
    endtask

    task automatic check_window(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s scoreboard: no expected sample for win_%0d", tag, k);
            end else begin
                cur_win[k] = exp_q.pop_front();
                chk($sformatf("%s win_%0d", tag, k), 32'(win_obs[k]), 32'(cur_win[k]));
            end
        end
    endtask

    task automatic check_hold(input string tag);
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("%s hold win_%0d", tag, k), 32'(win_obs[k]), 32'(cur_win[k]));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, " pair_valid"}, 32'(bus.pair_valid), 32'd0);
        chk({tag, " sel"},        32'(bus.sel),        32'd0);
        chk({tag, " pair_last"},  32'(bus.pair_last),  32'd0);
        chk({tag, " busy"},       32'(bus.busy),       32'd0);
        chk({tag, " ovf"},        32'(bus.ovf),        32'd0);
        chk({tag, " drop_cnt"},   32'(bus.drop_cnt),   32'd0);
        chk({tag, " state"},      32'(state_dbg),      32'(IDLE));
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("%s win_%0d", tag, k), 32'(win_obs[k]), 32'd0);
    endtask

    // Five consumed beats with pair_ready held high.
    task automatic beats(input string tag);
        for (int s = 0; s < NPAIR; s++) begin
            chk($sformatf("%s beat%0d pair_valid", tag, s), 32'(bus.pair_valid), 32'd1);
            chk($sformatf("%s beat%0d sel", tag, s),        32'(bus.sel),        32'(s));
            chk($sformatf("%s beat%0d pair_last", tag, s),  32'(bus.pair_last),  32'(s == NPAIR - 1));
            tick();
        end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.pair_ready   = 1'b0;

        // Cycle table: inputs for the cycle, outputs expected in that cycle.
        vt[0]  = '{1'b1, 9'd1,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 9'd2,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 9'd3,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 9'd4,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 9'd5,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 9'd6,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 9'd7,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 9'd8,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 9'd9,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 9'd10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 9'd0,  1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 9'd0,  1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 9'd0,  1'b1, 1'b1, 3'd1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 9'd0,  1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
        vt[14] = '{1'b0, 9'd0,  1'b1, 1'b1, 3'd3, 1'b0, 1'b1};
        vt[15] = '{1'b0, 9'd0,  1'b1, 1'b1, 3'd4, 1'b1, 1'b1};
        vt[16] = '{1'b0, 9'd0,  1'b1, 1'b0, 3'd0, 1'b0, 1'b0};

        // Reset.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_zero_outputs("reset");

        // Basic window 1..10, continuous, pair_ready high.
        for (int r = 0; r < 17; r++) begin
            chk($sformatf("row%0d pair_valid", r), 32'(bus.pair_valid), 32'(vt[r].pv));
            chk($sformatf("row%0d sel", r),        32'(bus.sel),        32'(vt[r].sel));
            chk($sformatf("row%0d pair_last", r),  32'(bus.pair_last),  32'(vt[r].last));
            chk($sformatf("row%0d busy", r),       32'(bus.busy),       32'(vt[r].busy));
            if (r == 11) check_window("basic");
            else if (r > 11 && r < 16) check_hold($sformatf("basic row%0d", r));
            bus.sample_valid = vt[r].sv;
            bus.sample_in    = vt[r].din;
            bus.pair_ready   = vt[r].pr;
            if (vt[r].sv) exp_q.push_back(vt[r].din);
            tick();
        end

        // Reset mid-window: partial samples must not leak into the next window.
        for (int i = 0; i < 5; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 9'(70 + i);
            tick();
        end
        bus.sample_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_zero_outputs("mid reset");
        bus.pair_ready = 1'b1;
        send_window(-100, 1);
        wait_pv("fresh", 5);
        check_window("fresh");
        beats("fresh");
        chk("fresh idle pair_valid", 32'(bus.pair_valid), 32'd0);

        // Backpressure at sel=2 for three cycles.
        bus.pair_ready = 1'b0;
        send_window(11, 1);
        wait_pv("bp", 5);
        check_window("bp");
        bus.pair_ready = 1'b1;
        tick();
        chk("bp sel1", 32'(bus.sel), 32'd1);
        tick();
        chk("bp sel2", 32'(bus.sel), 32'd2);
        bus.pair_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bp stall%0d sel", i),        32'(bus.sel),        32'd2);
            chk($sformatf("bp stall%0d pair_valid", i), 32'(bus.pair_valid), 32'd1);
            check_hold($sformatf("bp stall%0d", i));
        end
        bus.pair_ready = 1'b1;
        tick();
        chk("bp sel3", 32'(bus.sel), 32'd3);
        tick();
        chk("bp sel4", 32'(bus.sel), 32'd4);
        chk("bp pair_last", 32'(bus.pair_last), 32'd1);
        tick();
        chk("bp idle pair_valid", 32'(bus.pair_valid), 32'd0);

        // Back-to-back: second window pending while the first is held.
        bus.pair_ready = 1'b0;
        send_window(21, 1);
        wait_pv("b2b A", 5);
        check_window("b2b A");
        send_window(31, 1);
        chk("b2b stalled sel", 32'(bus.sel), 32'd0);
        chk("b2b busy", 32'(bus.busy), 32'd1);
        chk("b2b state", 32'(state_dbg), 32'(SEQ));
        bus.pair_ready = 1'b1;
        beats("b2b A");
        chk("b2b B no gap pair_valid", 32'(bus.pair_valid), 32'd1);
        chk("b2b B sel", 32'(bus.sel), 32'd0);
        check_window("b2b B");
        beats("b2b B");
        chk("b2b idle pair_valid", 32'(bus.pair_valid), 32'd0);

        // Overflow: 30 samples with pair_ready low, last 10 dropped.
        bus.pair_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 9'(50 + i);
            if (i < 20) exp_q.push_back(9'(50 + i));
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("ovf drop_cnt", 32'(bus.drop_cnt), OVF_EN ? 32'd10 : 32'd0);
        chk("ovf flag", 32'(bus.ovf), 32'(OVF_EN));
        chk("ovf busy", 32'(bus.busy), 32'd1);
        check_window("ovf w1");
        bus.pair_ready = 1'b1;
        beats("ovf w1");
        check_window("ovf w2");
        beats("ovf w2");
        chk("ovf idle pair_valid", 32'(bus.pair_valid), 32'd0);
        chk("ovf sticky", 32'(bus.ovf), 32'(OVF_EN));

        // Gapped input: one sample every third cycle.
        send_window(100, 3);
        wait_pv("gap", 5);
        check_window("gap");
        beats("gap");
        chk("gap idle pair_valid", 32'(bus.pair_valid), 32'd0);

        // Drop counter saturation: 10 earlier + 260 new drops.
        bus.pair_ready = 1'b0;
        for (int i = 0; i < 280; i++) begin
            bus.sample_valid = 1'b1;
            bus.sample_in    = 9'(i);
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("sat drop_cnt", 32'(bus.drop_cnt), OVF_EN ? 32'd255 : 32'd0);
        chk("sat ovf", 32'(bus.ovf), 32'(OVF_EN));
        chk("sat state", 32'(state_dbg), 32'(SEQ));

        // Reset mid-sequence with a pending window.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_zero_outputs("seq reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
